// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder FSM state type.
package ahb_pkg;

    // Transfer type encodings (HTRANS)
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Transfer size encodings (HSIZE); anything above WORD is illegal
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Response encodings (HRESP)
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Data-phase FSM of the responder
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Byte lanes touched by a transfer; illegal sizes fall back to a full word
    function automatic logic [3:0] lane_enable(input logic [2:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_mem_responder_mem.sv
// resp_mem: DEPTH_WORDS x 32 storage, asynchronous read, byte-enable write.
module resp_mem #(
    parameter  int DEPTH_WORDS = 256,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // NOTE: the array has no reset; its contents survive rst and a reset loop
    // over every word would only cost logic for data nobody may rely on.
    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane write: only enabled lanes are updated
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder: AHB-Lite memory slave with configurable wait states.
// Optional error responses are compiled in with macro AHB_RESP_ERROR_EN;
// without it HRESP stays OKAY, addresses wrap and misaligned bits are ignored.
module ahb_mem_responder
    import ahb_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW-1:0]   word_q;
    logic [1:0]      lo_q;
    logic [2:0]      size_q;
    logic            write_q;
    logic            bus_ready;
    logic            accept;
    logic            addr_err;
    logic [3:0]      mem_be;
    logic [31:0]     mem_rdata;

    // Only WAIT and the first error cycle stretch the data phase
    assign bus_ready = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign accept    = HSEL && HTRANS[1] && bus_ready;

    // BUSY and IDLE share HTRANS[1]=0, so the low bit carries no information here
    logic unused_htrans_lsb;
    assign unused_htrans_lsb = HTRANS[0];

`ifdef AHB_RESP_ERROR_EN
    // Flag out-of-range, illegal-size and misaligned address phases
    always_comb begin
        addr_err = 1'b0;
        if (HADDR >= 32'(4 * DEPTH_WORDS))                   addr_err = 1'b1;
        if (HSIZE > HSIZE_WORD)                              addr_err = 1'b1;
        if (HSIZE == HSIZE_HALF && HADDR[0])                 addr_err = 1'b1;
        if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)      addr_err = 1'b1;
    end
`else
    assign addr_err = 1'b0;

    // Upper address bits are dropped so accesses wrap modulo the array size
    logic unused_haddr_hi;
    assign unused_haddr_hi = ^HADDR[31:AW+2];
`endif

    // Next-state logic: advance the data phase, then let a new acceptance win
    // NOTE: every always_comb output gets a default first so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_DATA;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            if (addr_err) begin
                state_d = ST_ERR1;
                cnt_d   = 3'd0;
            end else if (WAIT_CYCLES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_INIT;
            end else begin
                state_d = ST_DATA;
                cnt_d   = 3'd0;
            end
        end
    end

    // State, wait counter and registered address phase
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            word_q  <= '0;
            lo_q    <= 2'b00;
            size_q  <= HSIZE_WORD;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                word_q  <= HADDR[AW+1:2];
                lo_q    <= HADDR[1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end
        end
    end

    // Commit the write on the edge that completes its DATA cycle, never in reset
    always_comb begin
        mem_be = 4'b0000;
        if (!rst && state_q == ST_DATA && write_q) begin
            mem_be = lane_enable(size_q, lo_q);
        end
    end

    // A read accepted alongside a completing write always reaches its DATA
    // cycle after the commit edge; the asynchronous array read therefore
    // returns the merged word without a separate bypass path.
    resp_mem #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mem (
        .clk  (clk),
        .be   (mem_be),
        .addr (word_q),
        .wdata(HWDATA),
        .rdata(mem_rdata)
    );

    // Bus outputs decoded from the state; reset forces the idle response
    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = 32'h0;
        if (!rst) begin
            case (state_q)
                ST_WAIT: HREADY = 1'b0;
                ST_DATA: if (!write_q) HRDATA = mem_rdata;
                ST_ERR1: begin
                    HREADY = 1'b0;
                    HRESP  = HRESP_ERROR;
                end
                ST_ERR2: HRESP = HRESP_ERROR;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Directed bench: dut uses one wait state, dut0 has none (back-to-back case).
module tb_ahb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = 32'h0;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    logic        b_hsel = 1'b0;
    logic [31:0] b_haddr = 32'h0;
    logic [1:0]  b_htrans = 2'b00;
    logic        b_hwrite = 1'b0;
    logic [2:0]  b_hsize = 3'b010;
    logic [31:0] b_hwdata = 32'h0;
    logic [31:0] b_hrdata;
    logic        b_hready;
    logic        b_hresp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ahb_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
    );

    ahb_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .HSEL(b_hsel), .HADDR(b_haddr), .HTRANS(b_htrans),
        .HWRITE(b_hwrite), .HSIZE(b_hsize), .HWDATA(b_hwdata),
        .HRDATA(b_hrdata), .HREADY(b_hready), .HRESP(b_hresp)
    );

    // Single transfer on dut; entered and left #1 after a rising edge
    task automatic ahb_xfer(input logic wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int low_cycles,
                            output logic resp_low, output logic resp_fin);
        hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
        hwdata = 32'h0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
        low_cycles = 0;
        resp_low   = 1'b0;
        while (hready !== 1'b1 && low_cycles < 16) begin
            resp_low = resp_low | hresp;
            low_cycles++;
            @(posedge clk); #1;
        end
        rdata    = hrdata;
        resp_fin = hresp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hready !== 1'b1) begin errors++; $display("FAIL reset_hready got=%b exp=1", hready); end
        checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp got=%b exp=0", hresp); end
        checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata got=%h exp=0", hrdata); end
        checks++; if (b_hready !== 1'b1) begin errors++; $display("FAIL reset_b_hready got=%b exp=1", b_hready); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; int low; logic rl, rf;
        ahb_xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, low, rl, rf);
        checks++; if (low !== 1) begin errors++; $display("FAIL wr_wait got=%0d exp=1", low); end
        checks++; if (rf !== 1'b0) begin errors++; $display("FAIL wr_hresp got=%b exp=0", rf); end
        ahb_xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, low, rl, rf);
        checks++; if (low !== 1) begin errors++; $display("FAIL rd_wait got=%0d exp=1", low); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        checks++; if (rf !== 1'b0) begin errors++; $display("FAIL rd_hresp got=%b exp=0", rf); end
        checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL idle_hrdata got=%h exp=0", hrdata); end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd; int low; logic rl, rf;
        ahb_xfer(1'b1, 32'h10, 3'b010, 32'h11223344, rd, low, rl, rf);
        ahb_xfer(1'b1, 32'h13, 3'b000, 32'hAA000000, rd, low, rl, rf);
        ahb_xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, low, rl, rf);
        checks++; if (rd !== 32'hAA223344) begin errors++; $display("FAIL byte_merge got=%h exp=aa223344", rd); end
        ahb_xfer(1'b1, 32'h10, 3'b001, 32'h00005566, rd, low, rl, rf);
        ahb_xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, low, rl, rf);
        checks++; if (rd !== 32'hAA225566) begin errors++; $display("FAIL half_merge got=%h exp=aa225566", rd); end
    endtask

    task automatic test_back_to_back();
        b_hsel = 1'b1; b_haddr = 32'h20; b_htrans = 2'b10; b_hwrite = 1'b1; b_hsize = 3'b010;
        @(posedge clk); #1;
        b_hwdata = 32'h12345678;
        b_haddr = 32'h20; b_htrans = 2'b10; b_hwrite = 1'b0;
        checks++; if (b_hready !== 1'b1) begin errors++; $display("FAIL b2b_wr_hready got=%b exp=1", b_hready); end
        checks++; if (b_hrdata !== 32'h0) begin errors++; $display("FAIL b2b_wr_hrdata got=%h exp=0", b_hrdata); end
        @(posedge clk); #1;
        b_hsel = 1'b0; b_htrans = 2'b00; b_hwdata = 32'h0;
        checks++; if (b_hready !== 1'b1) begin errors++; $display("FAIL b2b_rd_hready got=%b exp=1", b_hready); end
        checks++; if (b_hrdata !== 32'h12345678) begin errors++; $display("FAIL b2b_fwd got=%h exp=12345678", b_hrdata); end
        checks++; if (b_hresp !== 1'b0) begin errors++; $display("FAIL b2b_hresp got=%b exp=0", b_hresp); end
        @(posedge clk); #1;
    endtask

    task automatic test_error_path();
        logic [31:0] rd; int low; logic rl, rf;
        ahb_xfer(1'b1, 32'h0, 3'b010, 32'hCAFEF00D, rd, low, rl, rf);
        ahb_xfer(1'b0, 32'h400, 3'b010, 32'h0, rd, low, rl, rf);
        checks++; if (low !== 1) begin errors++; $display("FAIL oob_low got=%0d exp=1", low); end
`ifdef AHB_RESP_ERROR_EN
        checks++; if (rl !== 1'b1) begin errors++; $display("FAIL oob_err1 got=%b exp=1", rl); end
        checks++; if (rf !== 1'b1) begin errors++; $display("FAIL oob_err2 got=%b exp=1", rf); end
        ahb_xfer(1'b0, 32'h11, 3'b010, 32'h0, rd, low, rl, rf);
        checks++; if (rf !== 1'b1) begin errors++; $display("FAIL misalign_err got=%b exp=1", rf); end
`else
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL oob_wrap got=%h exp=cafef00d", rd); end
        checks++; if (rf !== 1'b0) begin errors++; $display("FAIL oob_hresp got=%b exp=0", rf); end
        ahb_xfer(1'b0, 32'h11, 3'b010, 32'h0, rd, low, rl, rf);
        checks++; if (rd !== 32'hAA225566) begin errors++; $display("FAIL misalign_word got=%h exp=aa225566", rd); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; int low; logic rl, rf;
        ahb_xfer(1'b1, 32'h30, 3'b010, 32'h55AA55AA, rd, low, rl, rf);
        hsel = 1'b1; haddr = 32'h30; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        checks++; if (hready !== 1'b0) begin errors++; $display("FAIL rstw_in_wait got=%b exp=0", hready); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (hready !== 1'b1) begin errors++; $display("FAIL rstw_hready got=%b exp=1", hready); end
        checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL rstw_hresp got=%b exp=0", hresp); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (hready !== 1'b1) begin errors++; $display("FAIL rstw_after got=%b exp=1", hready); end
        ahb_xfer(1'b0, 32'h30, 3'b010, 32'h0, rd, low, rl, rf);
        checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL rstw_mem got=%h exp=55aa55aa", rd); end
    endtask

    task automatic test_busy();
        logic [31:0] rd; int low; logic rl, rf;
        hsel = 1'b1; haddr = 32'h10; htrans = 2'b01; hwrite = 1'b1; hsize = 3'b010; hwdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (hready !== 1'b1) begin errors++; $display("FAIL busy_hready got=%b exp=1", hready); end
            checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL busy_hresp got=%b exp=0", hresp); end
        end
        hsel = 1'b0; htrans = 2'b00;
        @(posedge clk); #1;
        ahb_xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, low, rl, rf);
        checks++; if (rd !== 32'hAA225566) begin errors++; $display("FAIL busy_mem got=%h exp=aa225566", rd); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_merge();
        test_back_to_back();
        test_error_path();
        test_reset_mid_wait();
        test_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
